peak_tracker: RTL and testbench

Streaming peak detector that sits directly downstream of `comparator` and feeds it. Each cycle it drives the incoming sample and the running peak onto the comparator's `a`/`b` inputs. It consumes the returned `agb`/`alb`/`aeb` flags to decide whether to replace the peak. At frame end it reports the frame's maximum value and the index of its first occurrence.

---
 rtl/peak_tracker.sv | 189 ++++++++++++++++++
 tb/tb_peak_tracker.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/peak_tracker.sv
// peak_tracker: streaming peak detector paired with an external comparator #(n).
//
// Each cycle the incoming sample and the running peak are presented to the comparator on a/b;
// the returned agb/alb/aeb flags decide whether the peak is replaced. At frame end the frame
// maximum and the index of its first occurrence are reported with a one-cycle frame_done pulse.
//
// Optional feature: define PEAK_TIE_COUNT_EN to count samples equal to the current peak on
// tie_cnt. Without it tie_cnt is tied to zero; the port list is identical in both builds.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   din, din_valid      input sample and qualifier (always accepted)
//   din_last            final sample of a frame, qualified by din_valid
//   a, b                to comparator: a = din, b = peak register
//   agb, alb, aeb       from comparator, same cycle as a/b
//   peak, peak_idx      running/final maximum and index of its first occurrence
//   frame_done          one-cycle pulse, results final
//   busy                high while a frame is open
//   overflow            frame exceeded MAX_LEN samples (sticky per frame)
//   cmp_err             comparator flags not one-hot on a compared sample (sticky per frame)
//   tie_cnt             samples equal to the current peak (zero unless PEAK_TIE_COUNT_EN)

module peak_tracker #(
    parameter int unsigned n       = 4,
    parameter int unsigned MAX_LEN = 16,
    localparam int unsigned IW     = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [n-1:0]  din,
    input  logic          din_valid,
    input  logic          din_last,
    output logic [n-1:0]  a,
    output logic [n-1:0]  b,
    input  logic          agb,
    input  logic          alb,
    input  logic          aeb,
    output logic [n-1:0]  peak,
    output logic [IW-1:0] peak_idx,
    output logic          frame_done,
    output logic          busy,
    output logic          overflow,
    output logic          cmp_err,
    output logic [IW:0]   tie_cnt
);

    localparam logic [IW:0] CntMax = (IW+1)'(MAX_LEN);
    localparam logic [IW:0] CntOne = (IW+1)'(1);

    typedef enum logic [1:0] {StIdle, StTrack, StDone} state_e;

    state_e        state_q, state_d;
    logic [n-1:0]  peak_q, peak_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;

    logic first_s;   // sample opens a new frame (IDLE or DONE)
    logic cmp_s;     // sample is compared against the running peak
    logic flags_ok;  // exactly one of agb/alb/aeb set
    logic sat;       // counter already at MAX_LEN

    assign first_s  = din_valid && (state_q != StTrack);
    assign cmp_s    = din_valid && (state_q == StTrack);
    // Parity is 1 for one or three flags set; exclude the all-set case.
    assign flags_ok = (agb ^ alb ^ aeb) && !(agb && alb && aeb);
    assign sat      = (cnt_q == CntMax);

    assign a = din;
    assign b = peak_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (din_valid) begin
                    state_d = din_last ? StDone : StTrack;
                end else begin
                    state_d = StIdle;
                end
            end
            StTrack: begin
                if (din_valid && din_last) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy       = (state_q == StTrack);
        frame_done = (state_q == StDone);
    end

    // Peak datapath
    always_comb begin
        peak_d = peak_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        err_d  = err_q;
        if (first_s) begin
            // Flags are meaningless here: b still holds the previous frame's peak.
            peak_d = din;
            idx_d  = '0;
            cnt_d  = CntOne;
            ovf_d  = 1'b0;
            err_d  = 1'b0;
        end else if (cmp_s) begin
            cnt_d = sat ? cnt_q : cnt_q + CntOne;
            if (sat) begin
                ovf_d = 1'b1;
            end
            if (!flags_ok) begin
                err_d = 1'b1;
            end else if (agb) begin
                peak_d = din;
                // Past MAX_LEN the index is unrepresentable, so keep the prior one.
                if (!sat) begin
                    idx_d = cnt_q[IW-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            peak_q <= peak_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            err_q  <= err_d;
        end
    end

    assign peak     = peak_q;
    assign peak_idx = idx_q;
    assign overflow = ovf_q;
    assign cmp_err  = err_q;

`ifdef PEAK_TIE_COUNT_EN
    logic [IW:0] tie_q, tie_d;

    always_comb begin
        tie_d = tie_q;
        if (first_s) begin
            tie_d = CntOne;
        end else if (cmp_s && flags_ok) begin
            if (agb) begin
                tie_d = CntOne;
            end else if (aeb && (tie_q != CntMax)) begin
                tie_d = tie_q + CntOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tie_q <= '0;
        end else begin
            tie_q <= tie_d;
        end
    end

    assign tie_cnt = tie_q;
`else
    assign tie_cnt = '0;
`endif

endmodule

// File: tb/tb_peak_tracker.sv
// Testbench for peak_tracker with a behavioural 4-bit comparator attached. Expected results
// come from a frame-level model: max over the samples seen, first index of that max, and the
// number of samples equal to it.

module tb_peak_tracker;

    localparam int unsigned N       = 4;
    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned IW      = $clog2(MAX_LEN);

    logic          clk;
    logic          rst;
    logic [N-1:0]  din;
    logic          din_valid;
    logic          din_last;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          agb;
    logic          alb;
    logic          aeb;
    logic [N-1:0]  peak;
    logic [IW-1:0] peak_idx;
    logic          frame_done;
    logic          busy;
    logic          overflow;
    logic          cmp_err;
    logic [IW:0]   tie_cnt;

    logic fault;

    // Comparator, with a fault override that raises agb and aeb together.
    assign agb = fault ? 1'b1 : (a > b);
    assign aeb = fault ? 1'b1 : (a == b);
    assign alb = fault ? 1'b0 : (a < b);

    peak_tracker #(
        .n       (N),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_last   (din_last),
        .a          (a),
        .b          (b),
        .agb        (agb),
        .alb        (alb),
        .aeb        (aeb),
        .peak       (peak),
        .peak_idx   (peak_idx),
        .frame_done (frame_done),
        .busy       (busy),
        .overflow   (overflow),
        .cmp_err    (cmp_err),
        .tie_cnt    (tie_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors;
    int miscompares;

    int q[$];  // samples of the open frame
    int exp_peak;
    int exp_idx;
    int exp_tie;
    int exp_ovf;
    int exp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int tie_view(input int t);
`ifdef PEAK_TIE_COUNT_EN
        return t;
`else
        return 0 * t;
`endif
    endfunction

    // Frame-level reference: maximum, first index of it (frozen once past MAX_LEN), tie count.
    function automatic void model(output int pk, output int idx, output int ties);
        int first;
        int m;
        pk    = 0;
        idx   = 0;
        ties  = 0;
        first = -1;
        m     = -1;
        foreach (q[i]) if (q[i] > pk) pk = q[i];
        foreach (q[i]) begin
            if (q[i] == pk) begin
                ties++;
                if (first < 0) first = i;
            end
        end
        if (first < int'(MAX_LEN)) begin
            idx = first;
        end else begin
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                if (q[i] > m) begin
                    m   = q[i];
                    idx = i;
                end
            end
        end
        if (ties > int'(MAX_LEN)) ties = MAX_LEN;
    endfunction

    task automatic check_held(input string tag);
        chk({tag, "_peak"}, peak, exp_peak);
        chk({tag, "_idx"}, peak_idx, exp_idx);
        chk({tag, "_tie"}, tie_cnt, tie_view(exp_tie));
        chk({tag, "_ovf"}, overflow, exp_ovf);
        chk({tag, "_err"}, cmp_err, exp_err);
    endtask

    task automatic push(input int val, input bit last);
        int pk, idx, ties;
        @(negedge clk);
        din_valid = 1'b1;
        din       = N'(val);
        din_last  = last;
        #1;
        chk("a_eq_din", a, val);
        chk("b_eq_peak", b, exp_peak);
        @(posedge clk);
        #1;
        q.push_back(val);
        model(pk, idx, ties);
        exp_peak = pk;
        exp_idx  = idx;
        exp_tie  = ties;
        exp_ovf  = (q.size() > int'(MAX_LEN)) ? 1 : 0;
        exp_err  = 0;
        check_held("push");
        chk("push_busy", busy, !last);
        chk("push_done", frame_done, last);
        if (last) q.delete();
    endtask

    task automatic idle();
        @(negedge clk);
        din_valid = 1'b0;
        din       = N'($urandom_range(0, 15));
        din_last  = $urandom_range(0, 1);
        @(posedge clk);
        #1;
        check_held("idle");
        chk("idle_busy", busy, q.size() != 0);
        chk("idle_done", frame_done, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        din_valid = 1'b1;  // reset must win over a valid sample
        din       = 4'd13;
        din_last  = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        exp_peak = 0;
        exp_idx  = 0;
        exp_tie  = 0;
        exp_ovf  = 0;
        exp_err  = 0;
        check_held("rst");
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        @(negedge clk);
        rst       = 1'b0;
        din_valid = 1'b0;
    endtask

    initial begin
        int len;
        int lim;
        vectors     = 0;
        miscompares = 0;
        fault       = 1'b0;
        rst         = 1'b1;
        din         = '0;
        din_valid   = 1'b0;
        din_last    = 1'b0;
        exp_peak    = 0;
        exp_idx     = 0;
        exp_tie     = 0;
        exp_ovf     = 0;
        exp_err     = 0;
        repeat (2) @(posedge clk);
        #1;
        check_held("init");
        chk("init_busy", busy, 0);
        chk("init_done", frame_done, 0);
        @(negedge clk);
        rst = 1'b0;
        idle();

        // Rising frame with a tie on the peak
        push(3, 0); push(7, 0); push(2, 0); push(7, 1);
        idle();

        // Single-sample frame from IDLE
        push(9, 1);
        idle();

        // Back-to-back frames, no bubble
        push(1, 0); push(4, 1);
        push(15, 0); push(0, 1);
        idle();

        // Overflow: 17 samples, only the last is non-zero; then overflow clears
        for (int i = 0; i < 17; i++) push((i == 16) ? 5 : 0, i == 16);
        idle();
        push(2, 0);
        push(6, 1);

        // Tie count saturation with an overflowing all-equal frame
        for (int i = 0; i < 18; i++) push(7, i == 17);
        idle();

        // Flag fault on the compared sample of frame 2,8
        push(2, 0);
        @(negedge clk);
        din_valid = 1'b1;
        din       = 4'd8;
        din_last  = 1'b1;
        fault     = 1'b1;
        #1;
        chk("flt_b", b, 2);
        @(posedge clk);
        #1;
        fault = 1'b0;
        q.delete();
        exp_peak = 2;
        exp_idx  = 0;
        exp_tie  = 1;
        exp_ovf  = 0;
        exp_err  = 1;
        check_held("flt");
        chk("flt_done", frame_done, 1);
        chk("flt_busy", busy, 0);
        idle();
        push(4, 1);  // cmp_err cleared by the next first sample

        // Mid-frame reset, then a fresh frame
        push(6, 0); push(11, 0);
        do_reset();
        idle();
        push(3, 1);
        idle();

        // Randomised frames with idle gaps and back-to-back starts
        for (int k = 0; k < 40; k++) begin
            len = $urandom_range(1, 20);
            lim = ($urandom_range(0, 2) == 0) ? 2 : 15;
            for (int i = 0; i < len; i++) begin
                push($urandom_range(0, lim), i == len - 1);
                if ((i < len - 1) && ($urandom_range(0, 4) == 0)) idle();
            end
            if ($urandom_range(0, 1) == 0) idle();
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
